// File: rtl/rangefinder_sopc_sysid_checker.sv
// Reads the sys_id control slave (word 0 = system ID, word 1 = build
// timestamp) over Avalon-MM and compares both against the expected values.
module rangefinder_sopc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd320043385,
  parameter logic [31:0] EXPECTED_TS    = 32'd1496082079,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    ID_CMD,
    ID_WAIT,
    TS_CMD,
    TS_WAIT,
    FINISH
  } state_t;

  // Counter value seen during the last permitted cycle of a transaction.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic        w_last;
  logic        w_clr;
  logic        w_cnt_clr;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_set_to;

  assign w_last = (r_cnt == TO_LAST);

  // Next-state decode; a response in a CMD state (zero-latency slave) takes
  // priority over the timeout and skips the matching WAIT state.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_cnt_clr = 1'b0;
    w_cap_id  = 1'b0;
    w_cap_ts  = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next    = ID_CMD;
          w_clr     = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      ID_CMD: begin
        if (!waitrequest && readdatavalid) begin
          w_cap_id  = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = TS_CMD;
        end else if (w_last) begin
          w_set_to = 1'b1;
          w_next   = FINISH;
        end else if (!waitrequest) begin
          w_next = ID_WAIT;
        end
      end
      ID_WAIT: begin
        if (readdatavalid) begin
          w_cap_id  = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = TS_CMD;
        end else if (w_last) begin
          w_set_to = 1'b1;
          w_next   = FINISH;
        end
      end
      TS_CMD: begin
        if (!waitrequest && readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = FINISH;
        end else if (w_last) begin
          w_set_to = 1'b1;
          w_next   = FINISH;
        end else if (!waitrequest) begin
          w_next = TS_WAIT;
        end
      end
      TS_WAIT: begin
        if (readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = FINISH;
        end else if (w_last) begin
          w_set_to = 1'b1;
          w_next   = FINISH;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Per-transaction cycle counter, restarted on entry to each CMD state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (r_state == ID_CMD || r_state == ID_WAIT ||
                 r_state == TS_CMD || r_state == TS_WAIT) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Sticky results, cleared when a new sequence is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else if (w_clr) begin
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      if (w_cap_id) begin
        r_id_value <= readdata;
        r_id_ok    <= (readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= readdata;
        r_ts_ok    <= (readdata == EXPECTED_TS);
      end
      if (w_set_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign read     = (r_state == ID_CMD) || (r_state == TS_CMD);
  assign address  = (r_state == TS_CMD);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FINISH);
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_rangefinder_sopc_sysid_checker.sv
// Directed bench for rangefinder_sopc_sysid_checker: default-parameter
// instance for the main flows and a TIMEOUT_CYCLES=4 instance for timeouts.
module tb_rangefinder_sopc_sysid_checker;

  localparam logic [31:0] ID_V = 32'd320043385;
  localparam logic [31:0] TS_V = 32'd1496082079;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        start2;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;

  logic        address, read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        address2, read2, busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] id_value2, ts_value2;

  int n_total = 0;
  int n_bad   = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  always #5 clock = ~clock;

  rangefinder_sopc_sysid_checker u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .address(address), .read(read), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .readdata(readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  rangefinder_sopc_sysid_checker #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .address(address2), .read(read2), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .readdata(readdata),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2),
    .timeout(timeout2), .id_value(id_value2), .ts_value(ts_value2)
  );

  // Count accepted reads and done pulses at each active edge.
  always @(posedge clock) begin
    if (read && !waitrequest) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full sequence on the default instance with ws stall cycles on the ID read.
  task automatic run_seq(input logic [31:0] d_id, input logic [31:0] d_ts,
                         input int unsigned ws, input bit dup_start,
                         input logic exp_id_ok, input logic exp_ts_ok);
    int a0;
    int d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cmd_read", 32'(read), 1);
    chk("cmd_addr", 32'(address), 0);
    chk("cmd_busy", 32'(busy), 1);
    for (int unsigned i = 0; i < ws; i++) begin
      waitrequest = 1'b1;
      step();
      chk("stall_read", 32'(read), 1);
      chk("stall_addr", 32'(address), 0);
    end
    waitrequest = 1'b0;
    step();
    chk("idwait_read", 32'(read), 0);
    if (dup_start) start = 1'b1;
    readdatavalid = 1'b1;
    readdata = d_id;
    step();
    start = 1'b0;
    readdatavalid = 1'b0;
    readdata = '0;
    chk("ts_read", 32'(read), 1);
    chk("ts_addr", 32'(address), 1);
    step();
    chk("early_done", 32'(done), 0);
    readdatavalid = 1'b1;
    readdata = d_ts;
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    chk("done_pulse", 32'(done), 1);
    chk("id_ok", 32'(id_ok), 32'(exp_id_ok));
    chk("ts_ok", 32'(ts_ok), 32'(exp_ts_ok));
    chk("timeout_clr", 32'(timeout), 0);
    chk("id_value", id_value, d_id);
    chk("ts_value", ts_value, d_ts);
    if (dup_start) start = 1'b1;
    step();
    start = 1'b0;
    chk("done_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    step();
    chk("busy_after", 32'(busy), 0);
    chk("read_count", 32'(acc_cnt - a0), 2);
    chk("done_count", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int d2;
    reset_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    waitrequest = 1'b0;
    readdatavalid = 1'b0;
    readdata = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_read", 32'(read), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idok", 32'(id_ok), 0);
    chk("rst_idval", id_value, 0);
    reset_n = 1'b1;
    step();

    // Nominal pass, ID mismatch, stalled ID read, single-bit mismatches.
    run_seq(ID_V, TS_V, 0, 1'b0, 1'b1, 1'b1);
    run_seq(32'h0000_0001, TS_V, 0, 1'b0, 1'b0, 1'b1);
    run_seq(ID_V, TS_V, 3, 1'b0, 1'b1, 1'b1);
    run_seq(ID_V ^ 32'h8000_0000, TS_V ^ 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0);
    // Restart while busy and in FINISH must be ignored.
    run_seq(ID_V, TS_V, 0, 1'b1, 1'b1, 1'b1);

    // Zero-latency slave: response together with acceptance.
    start = 1'b1;
    step();
    start = 1'b0;
    readdatavalid = 1'b1;
    readdata = ID_V;
    step();
    chk("zl_ts_read", 32'(read), 1);
    chk("zl_ts_addr", 32'(address), 1);
    readdata = TS_V;
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    chk("zl_done", 32'(done), 1);
    chk("zl_idok", 32'(id_ok), 1);
    chk("zl_tsok", 32'(ts_ok), 1);
    step();

    // Response while idle is ignored.
    readdatavalid = 1'b1;
    readdata = 32'h0000_0001;
    step();
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    chk("idle_rdv_val", id_value, ID_V);
    chk("idle_rdv_busy", 32'(busy), 0);

    // Timeout on the TS read (TIMEOUT_CYCLES=4).
    d2 = done2_cnt;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    readdatavalid = 1'b1;
    readdata = ID_V;
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    chk("to_ts_read", 32'(read2), 1);
    step();
    step();
    step();
    chk("to_not_yet", 32'(done2), 0);
    chk("to_busy", 32'(busy2), 1);
    step();
    chk("to_done", 32'(done2), 1);
    chk("to_flag", 32'(timeout2), 1);
    chk("to_tsok", 32'(ts_ok2), 0);
    chk("to_tsval", ts_value2, 0);
    chk("to_idok", 32'(id_ok2), 1);
    step();
    chk("to_done_end", 32'(done2), 0);
    chk("to_done_cnt", 32'(done2_cnt - d2), 1);

    // Timeout with waitrequest stuck high on the ID read.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    waitrequest = 1'b1;
    step();
    step();
    step();
    chk("tow_read", 32'(read2), 1);
    step();
    waitrequest = 1'b0;
    chk("tow_read_off", 32'(read2), 0);
    chk("tow_done", 32'(done2), 1);
    chk("tow_flag", 32'(timeout2), 1);
    chk("tow_idval", id_value2, 0);
    step();

    // Asynchronous reset in TS_WAIT, late response ignored, then rerun.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    readdatavalid = 1'b1;
    readdata = ID_V;
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_read", 32'(read), 0);
    chk("ar_addr", 32'(address), 0);
    chk("ar_idok", 32'(id_ok), 0);
    chk("ar_idval", id_value, 0);
    chk("ar_to2", 32'(timeout2), 0);
    step();
    reset_n = 1'b1;
    readdatavalid = 1'b1;
    readdata = TS_V;
    step();
    readdatavalid = 1'b0;
    readdata = '0;
    chk("late_busy", 32'(busy), 0);
    chk("late_tsval", ts_value, 0);
    chk("late_tsok", 32'(ts_ok), 0);
    run_seq(ID_V, TS_V, 0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rangefinder_sopc_sysid_checker.md
RANGEFINDER_SOPC_SYSID_CHECKER -- requirements
Module: rangefinder_sopc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 320043385, is the 32-bit system ID expected at word address 0.
REQ-002 Parameter EXPECTED_TS, default 1496082079, is the 32-bit build timestamp expected at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, is the maximum cycles per read transaction (range 1..65535).
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse requesting a check sequence.
REQ-007 address  out  1  Avalon-MM word address to sys_id control slave (0 = ID, 1 = timestamp).
REQ-008 read  out  1  Avalon-MM read strobe.
REQ-009 waitrequest  in  1  slave stall; command held while high.
REQ-010 readdatavalid  in  1  qualifies readdata.
REQ-011 readdata  in  32  read response data.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  one-cycle pulse at end of sequence (pass, fail or timeout).
REQ-014 id_ok / ts_ok  out  1 each  sticky compare results, valid when done pulses.
REQ-015 timeout  out  1  sticky; set when any read exceeds TIMEOUT_CYCLES.
REQ-016 id_value / ts_value  out  32 each  captured readdata for address 0 / 1.

Function
REQ-017 FSM states SHALL be IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, FINISH.
- IDLE: start=1 -> ID_CMD; clears id_ok, ts_ok, timeout, id_value, ts_value same edge.
- ID_CMD: read=1, address=0; waitrequest=0 -> ID_WAIT.
- ID_WAIT: read=0; readdatavalid=1 -> capture id_value, id_ok=(readdata==EXPECTED_ID), -> TS_CMD.
- TS_CMD: read=1, address=1; waitrequest=0 -> TS_WAIT.
- TS_WAIT: readdatavalid=1 -> capture ts_value, ts_ok=(readdata==EXPECTED_TS), -> FINISH.
- FINISH: done=1 for exactly one cycle, -> IDLE.
REQ-018 read SHALL be asserted only in ID_CMD/TS_CMD; address and read held stable while waitrequest=1.
REQ-019 readdatavalid in ID_CMD/TS_CMD (same cycle as command acceptance, zero-latency slave) SHALL be accepted as that read's response and skip the WAIT state.
REQ-020 readdatavalid in IDLE or FINISH SHALL be ignored.
REQ-021 A 16-bit timeout counter SHALL clear on entering each CMD state and increment every cycle in CMD and WAIT states; reaching TIMEOUT_CYCLES without response sets timeout=1, deasserts read, -> FINISH; unread value keeps 0 and its ok flag 0.
REQ-022 start while busy=1 SHALL be ignored; start in FINISH cycle ignored.
REQ-023 busy SHALL be 1 in all states except IDLE; minimum sequence start->done = 5 cycles with waitrequest=0 and readdatavalid one cycle after acceptance.
REQ-024 Compare is full 32-bit equality; no partial matches.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, read=0, address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, counter=0, including mid-transaction; an in-flight response after reset release is ignored.

Verification
REQ-026 Start, slave returns 320043385 then 1496082079, no wait -> done after 5 cycles, id_ok=1, ts_ok=1, timeout=0.
REQ-027 Slave returns 0x00000001 at address 0 -> id_ok=0, id_value=1, ts_ok=1.
REQ-028 waitrequest held high 3 cycles on ID read -> read/address stable all 3 cycles, single read accepted, result pass.
REQ-029 TIMEOUT_CYCLES=4, readdatavalid never asserted on TS read -> timeout=1, ts_ok=0, ts_value=0, done pulses once.
REQ-030 reset_n low during TS_WAIT -> all outputs 0 asynchronously; late readdatavalid ignored; new start runs normally.
REQ-031 Second start pulse while busy -> ignored; exactly one done pulse and one read per address.
